fetch_fifo: RTL and testbench
=============================

# fetch_fifo

Instruction fetch queue between the instruction fetch unit and the ID stage. It accepts one fetched word per cycle, with its PC, branch-prediction hint and fetch exception, and stores it in a circular buffer. It presents the oldest entry to decode as a `fetch_entry` with a valid/ack handshake. It decouples I-cache latency from decode stalls and drops all queued work on a pipeline flush (mispredict, exception, `sfence.vma`).

## Interface
Parameters:
- `DEPTH`, default 4: number of entries. Must be a power of two and ≥ 2.

Ports (clock and reset: one clock; reset is asynchronous and active-high):
- `clk_i`  in  1  clock
- `rst_i`  in  1  asynchronous active-high reset
- `flush_i`  in  1  discard all entries
- `fetch_valid_i`  in  1  upstream word valid
- `fetch_ready_o`  out  1  queue can accept a word
- `fetch_address_i`  in  64  PC of the word
- `fetch_rdata_i`  in  32  instruction word
- `fetch_bp_i`  in  `branchpredict_sbe`  prediction hint
- `fetch_ex_i`  in  `exception`  fetch exception
- `fetch_entry_o`  out  `fetch_entry`  head entry
- `fetch_entry_valid_o`  out  1  head entry valid
- `fetch_ack_i`  in  1  decode consumed the head
- `entries_o`  out  `$clog2(DEPTH+1)`  current occupancy

## Operation
- State:
  - `DEPTH` × `fetch_entry` storage
  - read pointer and write pointer, `$clog2(DEPTH)` bits each, wrap modulo `DEPTH`
  - count, 0..`DEPTH`
- Push = `fetch_valid_i && fetch_ready_o`. It writes `{fetch_address_i, fetch_rdata_i, fetch_bp_i, ex}` at the write pointer, then increments the write pointer.
- Exception tval fill on push: if `fetch_ex_i.valid` and the cause is `INSTR_ACCESS_FAULT` or `INSTR_PAGE_FAULT`, the stored `ex.tval` is `fetch_address_i`. Otherwise `fetch_ex_i` is stored unchanged.
- Pop = `fetch_entry_valid_o && fetch_ack_i`. It increments the read pointer. `fetch_ack_i` with an empty queue is ignored.
- `fetch_entry_o` = storage at the read pointer.
- `fetch_entry_valid_o` = (count ≠ 0).
- `fetch_ready_o` = (count < `DEPTH`) && !`flush_i`. It depends only on registered state and `flush_i`, never on `fetch_ack_i`.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full and popping in the same cycle: no push, because `fetch_ready_o` is 0. Space frees one cycle later.
- Flush: on the next edge, count and both pointers go to 0. Any push or pop in the flush cycle is discarded. Storage contents are not cleared.
- `entries_o` = count.

## Timing
- Reset values:
  - count = 0, pointers = 0, all storage = 0
  - `fetch_entry_valid_o` = 0, `fetch_entry_o` = 0, `entries_o` = 0
  - `fetch_ready_o` = 1 (while `flush_i` = 0)
- Reset mid-operation clears all state asynchronously. Outputs take their reset values immediately.
- Latency: a word pushed at edge N appears on `fetch_entry_o` with valid after edge N. Minimum 1 cycle; there is no combinational bypass from input to output.
- Throughput: one push and one pop per cycle sustained at any occupancy below `DEPTH`.
- Wrap-around: a pointer at `DEPTH-1` advances to 0. Ordering is strictly FIFO across the wrap.
- Flush asserted for multiple cycles holds the queue empty and `fetch_ready_o` = 0.

## Structure
- `fetch_entry`, `branchpredict_sbe`, `exception` and the exception cause codes are already in `ariane_pkg`.
- Add `localparam FETCH_FIFO_DEPTH = 4` to `ariane_pkg`. The instantiating top level passes it as `DEPTH`.
- Flat module. Pointer, count and storage logic are small, and a generic FIFO sub-module would obscure the tval fill and flush semantics.

## Test plan
- Reset then idle:
  - `fetch_ready_o`=1, `fetch_entry_valid_o`=0, `entries_o`=0.
- Push 4 words while `fetch_ack_i`=0 (PCs 0x80, 0x84, 0x88, 0x8C; rdata 0x00000013, 0x00100093, 0x00200113, 0x00300193):
  - after 4 edges, `entries_o`=4 and `fetch_ready_o`=0
  - a 5th push attempt is not accepted
  - then ack 4 times: outputs PC 0x80, 0x84, 0x88, 0x8C in order, rdata matching
- Continuous push and ack for 10 cycles starting from 1 entry:
  - `entries_o` stays 1
  - PCs emerge in order across pointer wrap
- Full queue, `flush_i`=1 with `fetch_valid_i`=1 and `fetch_ack_i`=1:
  - next cycle `entries_o`=0, `fetch_entry_valid_o`=0
  - `fetch_ready_o`=0 during flush, 1 after
- Push with `fetch_ex_i` = {valid=1, cause=`INSTR_PAGE_FAULT`, tval=0} at PC 0x1000:
  - head `ex.tval`=0x1000, `ex.cause`=12
- Push with cause=`BREAKPOINT` and tval=0xDEAD:
  - tval stored unchanged as 0xDEAD

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared core types used by the fetch path: fetch exception, branch hint,
// the fetch queue entry, cause codes and the fetch queue depth.
package ariane_pkg;

  localparam int unsigned FETCH_FIFO_DEPTH = 4;

  // Synchronous exception cause codes (mcause encoding)
  localparam logic [63:0] INSTR_ADDR_MISALIGNED = 64'd0;
  localparam logic [63:0] INSTR_ACCESS_FAULT    = 64'd1;
  localparam logic [63:0] ILLEGAL_INSTR         = 64'd2;
  localparam logic [63:0] BREAKPOINT            = 64'd3;
  localparam logic [63:0] LD_ADDR_MISALIGNED    = 64'd4;
  localparam logic [63:0] LD_ACCESS_FAULT       = 64'd5;
  localparam logic [63:0] ST_ADDR_MISALIGNED    = 64'd6;
  localparam logic [63:0] ST_ACCESS_FAULT       = 64'd7;
  localparam logic [63:0] ENV_CALL_UMODE        = 64'd8;
  localparam logic [63:0] ENV_CALL_SMODE        = 64'd9;
  localparam logic [63:0] ENV_CALL_MMODE        = 64'd11;
  localparam logic [63:0] INSTR_PAGE_FAULT      = 64'd12;
  localparam logic [63:0] LOAD_PAGE_FAULT       = 64'd13;
  localparam logic [63:0] STORE_PAGE_FAULT      = 64'd15;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception;

  typedef struct packed {
    logic        valid;
    logic [63:0] predict_address;
    logic        predict_taken;
  } branchpredict_sbe;

  typedef struct packed {
    logic [63:0]      address;
    logic [31:0]      instruction;
    branchpredict_sbe branch_predict;
    exception         ex;
  } fetch_entry;

  // Fetch faults whose tval must carry the faulting PC
  function automatic logic is_fetch_fault(input logic [63:0] cause);
    return (cause == INSTR_ACCESS_FAULT) || (cause == INSTR_PAGE_FAULT);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction fetch queue: circular buffer between fetch and decode.
// One push and one pop per cycle, flush empties the queue on the next edge.
// No bypass: a pushed word is visible to decode one cycle later at the earliest.
module fetch_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         fetch_valid_i,
  output logic                         fetch_ready_o,
  input  logic [63:0]                  fetch_address_i,
  input  logic [31:0]                  fetch_rdata_i,
  input  branchpredict_sbe             fetch_bp_i,
  input  exception                     fetch_ex_i,
  output fetch_entry                   fetch_entry_o,
  output logic                         fetch_entry_valid_o,
  input  logic                         fetch_ack_i,
  output logic [$clog2(DEPTH+1)-1:0]   entries_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_entry      mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  fetch_entry      wdata;
  logic            push, pop;

  // Handshakes; ready never looks at ack, so a full queue cannot push while popping
  assign fetch_ready_o       = (count < CW'(DEPTH)) && !flush_i;
  assign fetch_entry_valid_o = (count != '0);
  assign push                = fetch_valid_i && fetch_ready_o;
  assign pop                 = fetch_entry_valid_o && fetch_ack_i;
  assign fetch_entry_o       = mem[rd_ptr];
  assign entries_o           = count;

  // Build the stored entry; fetch faults record the faulting PC as tval
  always_comb begin
    wdata                = '0;
    wdata.address        = fetch_address_i;
    wdata.instruction    = fetch_rdata_i;
    wdata.branch_predict = fetch_bp_i;
    wdata.ex             = fetch_ex_i;
    if (fetch_ex_i.valid && is_fetch_fault(fetch_ex_i.cause))
      wdata.ex.tval = fetch_address_i;
  end

  // Storage write; push is already masked by flush through fetch_ready_o
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; flush wins over any push/pop in the same cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_fifo.sv
// Directed bench for fetch_fifo with a scoreboard of expected head entries.
module tb_fetch_fifo;
  import ariane_pkg::*;

  localparam int DEPTH = FETCH_FIFO_DEPTH;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             flush_i;
  logic             fetch_valid_i;
  logic             fetch_ready_o;
  logic [63:0]      fetch_address_i;
  logic [31:0]      fetch_rdata_i;
  branchpredict_sbe fetch_bp_i;
  exception         fetch_ex_i;
  fetch_entry       fetch_entry_o;
  logic             fetch_entry_valid_o;
  logic             fetch_ack_i;
  logic [$clog2(DEPTH+1)-1:0] entries_o;

  fetch_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .flush_i             (flush_i),
    .fetch_valid_i       (fetch_valid_i),
    .fetch_ready_o       (fetch_ready_o),
    .fetch_address_i     (fetch_address_i),
    .fetch_rdata_i       (fetch_rdata_i),
    .fetch_bp_i          (fetch_bp_i),
    .fetch_ex_i          (fetch_ex_i),
    .fetch_entry_o       (fetch_entry_o),
    .fetch_entry_valid_o (fetch_entry_valid_o),
    .fetch_ack_i         (fetch_ack_i),
    .entries_o           (entries_o)
  );

  always #5 clk_i = ~clk_i;

  int         n_vec = 0;
  int         n_err = 0;
  int         mcount = 0;
  fetch_entry sb [$];
  branchpredict_sbe z_bp;
  exception         z_ex;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic fetch_entry model(input logic [63:0] pc, input logic [31:0] rd,
                                       input branchpredict_sbe bp, input exception ex);
    fetch_entry e;
    e.address        = pc;
    e.instruction    = rd;
    e.branch_predict = bp;
    e.ex             = ex;
    if (ex.valid && (ex.cause == 64'd1 || ex.cause == 64'd12)) e.ex.tval = pc;
    return e;
  endfunction

  // One clock cycle: drive, check pre-edge outputs, update model, check post-edge
  task automatic cyc(input logic v, input logic [63:0] pc, input logic [31:0] rd,
                     input branchpredict_sbe bp, input exception ex,
                     input logic ack, input logic fl);
    logic exp_ready;
    fetch_entry head;
    fetch_valid_i   = v;
    fetch_address_i = pc;
    fetch_rdata_i   = rd;
    fetch_bp_i      = bp;
    fetch_ex_i      = ex;
    fetch_ack_i     = ack;
    flush_i         = fl;
    #1;
    exp_ready = (mcount < DEPTH) && !fl;
    chk("ready", 320'(fetch_ready_o), 320'(exp_ready));
    chk("valid", 320'(fetch_entry_valid_o), 320'(mcount != 0));
    if (ack && mcount != 0) begin
      head = sb[0];
      chk("head", 320'(fetch_entry_o), 320'(head));
      if (!fl) begin
        void'(sb.pop_front());
        mcount--;
      end
    end
    if (v && exp_ready) begin
      sb.push_back(model(pc, rd, bp, ex));
      mcount++;
    end
    @(posedge clk_i);
    #1;
    if (fl) begin
      sb.delete();
      mcount = 0;
    end
    chk("entries", 320'(entries_o), 320'(mcount));
  endtask

  task automatic idle_ack(input logic ack);
    cyc(1'b0, 64'h0, 32'h0, z_bp, z_ex, ack, 1'b0);
  endtask

  initial begin
    exception         ex;
    branchpredict_sbe bp;
    logic [31:0] words [4];
    words[0] = 32'h00000013; words[1] = 32'h00100093;
    words[2] = 32'h00200113; words[3] = 32'h00300193;
    z_bp = '0;
    z_ex = '0;
    rst_i = 1'b1; flush_i = 1'b0; fetch_valid_i = 1'b0; fetch_ack_i = 1'b0;
    fetch_address_i = '0; fetch_rdata_i = '0; fetch_bp_i = '0; fetch_ex_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready",   320'(fetch_ready_o), 320'(1'b1));
    chk("rst_valid",   320'(fetch_entry_valid_o), 320'(1'b0));
    chk("rst_entries", 320'(entries_o), 320'(0));
    chk("rst_entry",   320'(fetch_entry_o), 320'(0));
    rst_i = 1'b0;
    idle_ack(1'b0);

    // Fill to DEPTH with no ack, then a rejected 5th push
    for (int i = 0; i < 4; i++) begin
      bp = '0;
      bp.valid = 1'b1; bp.predict_taken = i[0]; bp.predict_address = 64'h400 + 64'(i);
      cyc(1'b1, 64'h80 + 64'(4*i), words[i], bp, z_ex, 1'b0, 1'b0);
    end
    chk("full_entries", 320'(entries_o), 320'(4));
    chk("full_ready",   320'(fetch_ready_o), 320'(1'b0));
    cyc(1'b1, 64'h90, 32'hDEADBEEF, z_bp, z_ex, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("order_pc", 320'(fetch_entry_o.address), 320'(64'h80 + 64'(4*i)));
      idle_ack(1'b1);
    end
    idle_ack(1'b1); // ack on empty queue is ignored

    // Streaming at occupancy 1 across pointer wrap
    cyc(1'b1, 64'h200, 32'h1000_0000, z_bp, z_ex, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 64'h200 + 64'(4*i), 32'h1000_0000 + 32'(i), z_bp, z_ex, 1'b1, 1'b0);
      chk("stream_entries", 320'(entries_o), 320'(1));
    end
    idle_ack(1'b1);

    // Flush a full queue while pushing and acking
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 64'h300 + 64'(4*i), 32'h2000_0000 + 32'(i), z_bp, z_ex, 1'b0, 1'b0);
    cyc(1'b1, 64'h400, 32'h0, z_bp, z_ex, 1'b1, 1'b1);
    chk("flush_valid", 320'(fetch_entry_valid_o), 320'(1'b0));
    cyc(1'b1, 64'h404, 32'h0, z_bp, z_ex, 1'b1, 1'b1);
    idle_ack(1'b0);
    chk("post_flush_ready", 320'(fetch_ready_o), 320'(1'b1));

    // Exception tval fill
    ex = '0; ex.valid = 1'b1; ex.cause = INSTR_PAGE_FAULT; ex.tval = 64'h0;
    cyc(1'b1, 64'h1000, 32'h0000_0073, z_bp, ex, 1'b0, 1'b0);
    chk("pf_tval",  320'(fetch_entry_o.ex.tval), 320'(64'h1000));
    chk("pf_cause", 320'(fetch_entry_o.ex.cause), 320'(64'd12));
    idle_ack(1'b1);
    ex.cause = BREAKPOINT; ex.tval = 64'hDEAD;
    cyc(1'b1, 64'h2000, 32'h0010_0073, z_bp, ex, 1'b0, 1'b0);
    chk("bp_tval", 320'(fetch_entry_o.ex.tval), 320'(64'hDEAD));
    idle_ack(1'b1);
    ex.cause = INSTR_ACCESS_FAULT; ex.tval = 64'h5;
    cyc(1'b1, 64'h3000, 32'h0, z_bp, ex, 1'b0, 1'b0);
    chk("af_tval", 320'(fetch_entry_o.ex.tval), 320'(64'h3000));
    idle_ack(1'b1);
    ex.valid = 1'b0; ex.cause = INSTR_PAGE_FAULT; ex.tval = 64'h7;
    cyc(1'b1, 64'h4000, 32'h0, z_bp, ex, 1'b0, 1'b0);
    chk("noex_tval", 320'(fetch_entry_o.ex.tval), 320'(64'h7));
    idle_ack(1'b1);

    // Asynchronous reset mid-operation
    cyc(1'b1, 64'h5000, 32'h1111_1111, z_bp, z_ex, 1'b0, 1'b0);
    cyc(1'b1, 64'h5004, 32'h2222_2222, z_bp, z_ex, 1'b0, 1'b0);
    rst_i = 1'b1;
    #1;
    chk("arst_entries", 320'(entries_o), 320'(0));
    chk("arst_valid",   320'(fetch_entry_valid_o), 320'(1'b0));
    chk("arst_entry",   320'(fetch_entry_o), 320'(0));
    sb.delete();
    mcount = 0;
    rst_i = 1'b0;
    cyc(1'b1, 64'h6000, 32'h3333_3333, z_bp, z_ex, 1'b0, 1'b0);
    idle_ack(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
